rx_frame_sequencer: RTL and testbench

- Receive-path controller for the decoder_cordic_cdr datapath.
- Releases the datapath from reset and generates the per-sample eoc strobe, gating 4-bit I/Q ADC samples onto i_if/q_if.
- After a warm-up period, hunts the recovered bit stream (data_out qualified by cdr_flag) for the SFD, then extracts the PHY length byte and delivers PSDU bytes.

---
 rtl/rx_frame_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_rx_frame_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_sequencer.sv
// rx_frame_sequencer
//   Receive-path controller for the decoder_cordic_cdr datapath. Releases the
//   datapath from reset, produces the per-sample eoc strobe that gates the
//   ADC samples onto i_if/q_if, then hunts the recovered bit stream for the
//   SFD, captures the PHY length byte and delivers the PSDU bytes.
//
// Ports
//   clk, reset           system clock, async active-high reset
//   rx_en                receiver enable (level)
//   adc_i, adc_q         raw 4-bit ADC samples
//   dp_reset_n           active-low reset to the datapath
//   eoc, i_if, q_if      sample strobe and gated samples to the datapath
//   data_out, cdr_flag   recovered bit and its qualifying strobe
//   byte_out, byte_valid PSDU byte and strobe
//   frame_len            length field of the current frame
//   sfd_found, frame_done, timeout   one-cycle status pulses
//   busy                 state != IDLE
module rx_frame_sequencer #(
  parameter int unsigned DIV          = 5,
  parameter int unsigned WARMUP       = 32,
  parameter int unsigned SYNC_TIMEOUT = 1024,
  parameter logic [7:0]  SFD          = 8'hA7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_en,
  input  logic [3:0] adc_i,
  input  logic [3:0] adc_q,
  output logic       dp_reset_n,
  output logic       eoc,
  output logic [3:0] i_if,
  output logic [3:0] q_if,
  input  logic       data_out,
  input  logic       cdr_flag,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic [6:0] frame_len,
  output logic       sfd_found,
  output logic       frame_done,
  output logic       timeout,
  output logic       busy
);

  localparam int unsigned WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int unsigned TW = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, WARMUP_S, HUNT, LEN, RECV} state_t;

  state_t         state, state_n;
  logic [3:0]     cnt, cnt_n;
  logic [WW-1:0]  warm_cnt, warm_n;
  logic [TW-1:0]  to_cnt, to_n;
  // Only the 7 most recent bits are kept; the incoming bit completes the byte.
  logic [6:0]     sr, sr_n;
  logic [7:0]     shift;
  logic [2:0]     bit_cnt, bit_n;
  logic [6:0]     remaining, rem_n;
  logic           eoc_n, bv_n, sfd_n, done_n, to_pulse_n;
  logic [3:0]     i_n, q_n;
  logic [7:0]     byte_out_n;
  logic [6:0]     frame_len_n;

  always_comb begin
    state_n     = state;
    cnt_n       = '0;
    eoc_n       = 1'b0;
    i_n         = '0;
    q_n         = '0;
    warm_n      = warm_cnt;
    to_n        = to_cnt;
    sr_n        = sr;
    bit_n       = bit_cnt;
    rem_n       = remaining;
    byte_out_n  = byte_out;
    frame_len_n = frame_len;
    bv_n        = 1'b0;
    sfd_n       = 1'b0;
    done_n      = 1'b0;
    to_pulse_n  = 1'b0;
    shift       = {data_out, sr};

    if (state == IDLE) begin
      warm_n = '0;
      to_n   = '0;
      sr_n   = '0;
      bit_n  = '0;
      rem_n  = '0;
      if (rx_en) state_n = WARMUP_S;
    end else if (!rx_en) begin
      state_n = IDLE;
    end else begin
      case (state)
        WARMUP_S: begin
          if (eoc) begin
            if (warm_cnt == WW'(WARMUP - 1)) begin
              state_n = HUNT;
              sr_n    = '0;
              to_n    = '0;
            end else begin
              warm_n = warm_cnt + WW'(1);
            end
          end
        end
        HUNT: begin
          if (cdr_flag) sr_n = shift[7:1];
          // SFD match takes precedence over a coincident timeout.
          if (cdr_flag && shift == SFD) begin
            sfd_n   = 1'b1;
            state_n = LEN;
            bit_n   = '0;
          end else if (eoc) begin
            if (to_cnt == TW'(SYNC_TIMEOUT - 1)) begin
              to_pulse_n = 1'b1;
              state_n    = IDLE;
            end else begin
              to_n = to_cnt + TW'(1);
            end
          end
        end
        LEN: begin
          if (cdr_flag) begin
            sr_n  = shift[7:1];
            bit_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              frame_len_n = shift[6:0];
              if (shift[6:0] == 7'd0) begin
                done_n  = 1'b1;
                state_n = HUNT;
                sr_n    = '0;
                to_n    = '0;
              end else begin
                rem_n   = shift[6:0];
                state_n = RECV;
              end
            end
          end
        end
        RECV: begin
          if (cdr_flag) begin
            sr_n  = shift[7:1];
            bit_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              byte_out_n = shift;
              bv_n       = 1'b1;
              rem_n      = remaining - 7'd1;
              if (remaining == 7'd1) begin
                done_n  = 1'b1;
                state_n = HUNT;
                sr_n    = '0;
                to_n    = '0;
              end
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end

    // Sample timer runs only while the datapath is released and stays released.
    if (dp_reset_n && state_n != IDLE) begin
      if (cnt == 4'(DIV - 1)) begin
        eoc_n = 1'b1;
        i_n   = adc_i;
        q_n   = adc_q;
      end else begin
        cnt_n = cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      warm_cnt   <= '0;
      to_cnt     <= '0;
      sr         <= '0;
      bit_cnt    <= '0;
      remaining  <= '0;
      dp_reset_n <= 1'b0;
      eoc        <= 1'b0;
      i_if       <= '0;
      q_if       <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      frame_len  <= '0;
      sfd_found  <= 1'b0;
      frame_done <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      warm_cnt   <= warm_n;
      to_cnt     <= to_n;
      sr         <= sr_n;
      bit_cnt    <= bit_n;
      remaining  <= rem_n;
      dp_reset_n <= (state_n != IDLE);
      eoc        <= eoc_n;
      i_if       <= i_n;
      q_if       <= q_n;
      byte_out   <= byte_out_n;
      byte_valid <= bv_n;
      frame_len  <= frame_len_n;
      sfd_found  <= sfd_n;
      frame_done <= done_n;
      timeout    <= to_pulse_n;
      busy       <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// tb_rx_frame_sequencer
//   Directed bench for rx_frame_sequencer. Expected status events are queued
//   when stimulus is issued and a negedge monitor pops and compares them.
module tb_rx_frame_sequencer;

  localparam int DIV = 5;
  localparam int EV_SFD = 0, EV_BYTE = 1, EV_DONE = 2, EV_TO = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_en = 1'b0;
  logic [3:0] adc_i = 4'h9;
  logic [3:0] adc_q = 4'h6;
  logic       data_out = 1'b0;
  logic       cdr_flag = 1'b0;
  logic       dp_reset_n, eoc, byte_valid, sfd_found, frame_done, timeout, busy;
  logic [3:0] i_if, q_if;
  logic [7:0] byte_out;
  logic [6:0] frame_len;

  rx_frame_sequencer #(
    .DIV(DIV), .WARMUP(32), .SYNC_TIMEOUT(1024), .SFD(8'hA7)
  ) dut (
    .clk(clk), .reset(reset), .rx_en(rx_en), .adc_i(adc_i), .adc_q(adc_q),
    .dp_reset_n(dp_reset_n), .eoc(eoc), .i_if(i_if), .q_if(q_if),
    .data_out(data_out), .cdr_flag(cdr_flag), .byte_out(byte_out),
    .byte_valid(byte_valid), .frame_len(frame_len), .sfd_found(sfd_found),
    .frame_done(frame_done), .timeout(timeout), .busy(busy)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         kind;
    logic [8:0] data;
  } ev_t;
  ev_t exp_q[$];

  function automatic void check(string name, longint act, longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endfunction

  function automatic void push(int k, logic [8:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  function automatic void pop_cmp(int k, logic [8:0] d, string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      check({name, "_unexpected"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({name, "_kind"}, k, e.kind);
      check({name, "_data"}, d, e.data);
    end
  endfunction

  // Monitor: every status pulse must match the next queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (sfd_found) pop_cmp(EV_SFD, 9'h0, "sfd");
        if (byte_valid) pop_cmp(EV_BYTE, {frame_done, byte_out}, "byte");
        else if (frame_done) pop_cmp(EV_DONE, 9'h0, "done");
        if (timeout) pop_cmp(EV_TO, 9'h0, "timeout");
      end
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic send_bit(input logic b);
    @(posedge clk); #1;
    data_out = b;
    cdr_flag = 1'b1;
    @(posedge clk); #1;
    cdr_flag = 1'b0;
    data_out = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic wait_eoc(input int n);
    int seen = 0;
    int budget = n * DIV + 50;
    while (seen < n && budget > 0) begin
      @(negedge clk);
      if (eoc) seen++;
      budget--;
    end
    if (seen < n) check("eoc_wait", seen, n);
  endtask

  initial begin
    int  eoc_cnt;
    int  budget;
    logic exp_eoc;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_dp_reset_n", dp_reset_n, 0);
    check("rst_eoc", eoc, 0);
    check("rst_busy", busy, 0);
    check("rst_i_if", i_if, 0);
    check("rst_byte_out", byte_out, 0);
    check("rst_frame_len", frame_len, 0);
    @(posedge clk); #1 reset = 1'b0;

    // 1: release and sample strobe cadence
    @(posedge clk); #1 rx_en = 1'b1;
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      if (k < 2) check("dp_reset_n_rise", dp_reset_n, (k >= 1) ? 1 : 0);
      exp_eoc = (k >= 6 && (k - 6) % 5 == 0);
      check("eoc_cadence", eoc, exp_eoc);
      check("i_if_gate", i_if, exp_eoc ? 4'h9 : 4'h0);
      check("q_if_gate", q_if, exp_eoc ? 4'h6 : 4'h0);
    end
    wait_eoc(29);

    // 2: SFD detection, pulse on the 8th bit's edge
    push(EV_SFD, 9'h0);
    send_byte(8'hA7);
    @(negedge clk);
    check("sfd_timing", sfd_found, 1);

    // 3: length 3, three bytes, done with the last byte
    send_byte(8'h03);
    @(negedge clk);
    check("frame_len_3", frame_len, 3);
    push(EV_BYTE, {1'b0, 8'h5A});
    push(EV_BYTE, {1'b0, 8'hC3});
    push(EV_BYTE, {1'b1, 8'h01});
    send_byte(8'h5A);
    send_byte(8'hC3);
    send_byte(8'h01);
    @(negedge clk);
    check("busy_after_frame", busy, 1);

    // 5: length byte 0x80 -> zero-length frame
    push(EV_SFD, 9'h0);
    push(EV_DONE, 9'h0);
    send_byte(8'hA7);
    send_byte(8'h80);

    // 4: timeout after 1024 eoc in HUNT, counted from the frame_done cycle
    push(EV_TO, 9'h0);
    @(negedge clk);
    check("frame_len_0x80", frame_len, 0);
    eoc_cnt = eoc ? 1 : 0;
    budget = 1100 * DIV;
    while (!timeout && budget > 0) begin
      @(negedge clk);
      if (eoc) eoc_cnt++;
      budget--;
    end
    check("timeout_seen", timeout, 1);
    check("timeout_eoc_count", eoc_cnt, 1024);
    check("timeout_dp_low", dp_reset_n, 0);
    check("timeout_busy", busy, 0);
    @(negedge clk);
    check("rewarm_dp_high", dp_reset_n, 1);
    check("rewarm_busy", busy, 1);
    // SFD during warm-up must be ignored
    send_byte(8'hA7);
    wait_eoc(32);
    push(EV_SFD, 9'h0);
    push(EV_DONE, 9'h0);
    send_byte(8'hA7);
    send_byte(8'h00);

    // 6: rx_en dropped after the first of three bytes
    push(EV_SFD, 9'h0);
    push(EV_BYTE, {1'b0, 8'h11});
    send_byte(8'hA7);
    send_byte(8'h03);
    send_byte(8'h11);
    rx_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_dp", dp_reset_n, 0);
    check("abort_eoc", eoc, 0);
    check("abort_byte_out", byte_out, 8'h11);
    check("abort_frame_len", frame_len, 3);
    send_byte(8'h44);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("eoc_stopped", eoc, 0);
    end

    // Async reset mid-RECV
    @(posedge clk); #1 rx_en = 1'b1;
    wait_eoc(32);
    push(EV_SFD, 9'h0);
    push(EV_BYTE, {1'b0, 8'h22});
    send_byte(8'hA7);
    send_byte(8'h03);
    send_byte(8'h22);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(posedge clk); #3 reset = 1'b1;
    #1;
    check("arst_dp", dp_reset_n, 0);
    check("arst_busy", busy, 0);
    check("arst_byte_out", byte_out, 0);
    check("arst_frame_len", frame_len, 0);
    check("arst_byte_valid", byte_valid, 0);
    check("arst_eoc", eoc, 0);
    repeat (3) @(negedge clk);
    check("scoreboard_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
